// File: rtl/spi_eeprom_arbiter_pkg.sv
// Shared types and helpers for the SPI EEPROM bus arbiter.
package spi_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, GUARD} state_t;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_NUM_DEV     = 4;
  localparam int DEF_SEL_W       = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_eeprom_arbiter_if.sv
// Master-side request/SPI lines and the shared EEPROM bus, bundled for the arbiter.
interface spi_arb_if import spi_arb_pkg::*; #(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int NUM_DEV     = DEF_NUM_DEV,
  parameter int SEL_W       = DEF_SEL_W
) ();
  logic [NUM_MASTERS-1:0]       req;
  logic [NUM_MASTERS*SEL_W-1:0] sel;
  logic [NUM_MASTERS-1:0]       cs_n_m;
  logic [NUM_MASTERS-1:0]       sclk_m;
  logic [NUM_MASTERS-1:0]       sdout_m;
  logic                         SDIN;
  logic                         SCLK;
  logic                         SDOUT;
  logic [NUM_DEV-1:0]           CSe;
  logic [NUM_MASTERS-1:0]       sdin_m;
  logic [NUM_MASTERS-1:0]       grant;
  logic                         busy;
  logic                         timeout;

  modport slave (
    input  req, sel, cs_n_m, sclk_m, sdout_m, SDIN,
    output SCLK, SDOUT, CSe, sdin_m, grant, busy, timeout
  );

  modport master (
    output req, sel, cs_n_m, sclk_m, sdout_m, SDIN,
    input  SCLK, SDOUT, CSe, sdin_m, grant, busy, timeout
  );
endinterface

// File: rtl/spi_eeprom_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr, one-hot plus index.
module rr_arbiter import spi_arb_pkg::*; #(
  parameter int N  = 2,
  parameter int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          found
);
  int idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[IW'(idx)] && mask[IW'(idx)]) begin
        found         = 1'b1;
        win_idx       = IW'(idx);
        win[IW'(idx)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_eeprom_arbiter.sv
// Round-robin SPI bus arbiter with held multi-frame grant, guard gap and CS decode.
// Optional CS-low watchdog with per-master lockout under `SPI_ARB_TIMEOUT_EN.
module spi_eeprom_arbiter import spi_arb_pkg::*; #(
  parameter int          NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int          NUM_DEV        = DEF_NUM_DEV,
  parameter int          SEL_W          = DEF_SEL_W,
  parameter int          GUARD_CYCLES   = 2,
  parameter logic        CPOL           = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic      clk,
  input logic      rst,
  spi_arb_if.slave bus
);
  localparam int IW    = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);
  localparam int GLAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

  if (NUM_MASTERS < 2 || (1 << SEL_W) < NUM_DEV || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("spi_eeprom_arbiter: unsupported parameter combination");
  end

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          gidx;
  logic [IW-1:0]          ptr;
  logic [SEL_W-1:0]       sel_q;
  logic [15:0]            gcnt;
  logic [NUM_MASTERS-1:0] win;
  logic [NUM_MASTERS-1:0] elig;
  logic [IW-1:0]          win_idx;
  logic                   found;
  logic                   cs_g;
  logic                   req_g;
  logic                   granted;

  assign cs_g    = bus.cs_n_m[gidx];
  assign req_g   = bus.req[gidx];
  assign granted = |grant_q;

  rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_rr (
    .req     (bus.req),
    .mask    (elig),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .found   (found)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0]            to_cnt;
  logic [NUM_MASTERS-1:0] lockout;
  logic                   timeout_q;
  logic                   to_hit;

  assign to_hit      = (state == ACTIVE) && !cs_g && (to_cnt == TIMEOUT_CYCLES - 1);
  assign elig        = ~lockout;
  assign bus.timeout = timeout_q;

  // Lockout holds until the offending master is seen with req low.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      lockout   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      lockout   <= lockout & bus.req;
      if (state == GRANT && !cs_g) to_cnt <= '0;
      else if (state == ACTIVE)    to_cnt <= to_cnt + 32'd1;
      if (to_hit) begin
        timeout_q     <= 1'b1;
        lockout[gidx] <= 1'b1;
      end
    end
  end
`else
  assign elig        = '1;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      gidx    <= '0;
      ptr     <= '0;
      sel_q   <= '0;
      gcnt    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_q <= win;
          gidx    <= win_idx;
          sel_q   <= bus.sel[win_idx*SEL_W +: SEL_W];
          ptr     <= (win_idx == IW'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
          state   <= GRANT;
        end
        GRANT: begin
          if (!cs_g) state <= ACTIVE;
          else if (!req_g) begin
            state   <= GUARD;
            grant_q <= '0;
            gcnt    <= '0;
          end
        end
        ACTIVE: begin
          if (cs_g) state <= GRANT;
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state   <= GUARD;
            grant_q <= '0;
            gcnt    <= '0;
          end
`endif
        end
        GUARD: begin
          if (gcnt == 16'(GLAST)) state <= IDLE;
          else gcnt <= gcnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus side is a pure mux on the registered grant: no added latency.
  assign bus.grant  = grant_q;
  assign bus.busy   = (state != IDLE);
  assign bus.SCLK   = granted ? bus.sclk_m[gidx]  : CPOL;
  assign bus.SDOUT  = granted ? bus.sdout_m[gidx] : 1'b0;
  assign bus.sdin_m = grant_q & {NUM_MASTERS{bus.SDIN}};

  always_comb begin
    bus.CSe = '1;
    if (state == GRANT || state == ACTIVE) begin
      for (int d = 0; d < NUM_DEV; d++) begin
        if (sel_q == SEL_W'(d)) bus.CSe[d] = cs_g;
      end
    end
  end
endmodule
